// File: rtl/spi_xfer_seq_if.sv
// Command/response streams plus the spi_master register port, bundled for the sequencer.
// The sequencer takes the slave modport; the host/master-side model takes the master modport.
interface spi_xfer_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [ADDR_W-1:0] spi_address;
  logic [DATA_W-1:0] spi_data_in;
  logic              spi_sel;
  logic              spi_we;
  logic [DATA_W-1:0] spi_data_out;

  modport slave (
    input  cmd_valid, cmd_data, cmd_rd, rsp_ready, spi_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output spi_address, spi_data_in, spi_sel, spi_we
  );

  modport master (
    output cmd_valid, cmd_data, cmd_rd, rsp_ready, spi_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  spi_address, spi_data_in, spi_sel, spi_we
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// Transfer sequencer for spi_master: write TX, poll READY (with settle window and
// timeout), optionally read RX, and return one response per accepted command.
module spi_xfer_seq #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] SPI_TX    = '0,
  parameter logic [ADDR_W-1:0] SPI_READY = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] SPI_RX    = ADDR_W'(2),
  parameter int                SETTLE    = 2,
  parameter int                TIMEOUT   = 65535
) (
  input  logic         clk,
  input  logic         rst,
  spi_xfer_seq_if.slave bus,
  output logic         busy,
  output logic [15:0]  xfer_cnt
);

  localparam logic [15:0] SETTLE_C    = 16'(SETTLE);
  localparam logic [15:0] POLL_LAST_C = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_POLL, S_RDA, S_RDD, S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              rd_q, rd_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;
  logic              sel, we, cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      addr_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      addr_q     <= addr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    xfer_cnt_d = xfer_cnt_q;
    addr_d     = addr_q;
    sel        = 1'b0;
    we         = 1'b0;
    cmd_ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A pending response only exists in S_RSP, so IDLE is always free to accept.
        cmd_ready = !rst;
        if (bus.cmd_valid && cmd_ready) begin
          tx_d    = bus.cmd_data;
          rd_d    = bus.cmd_rd;
          state_d = S_WR;
        end
      end
      S_WR: begin
        sel     = 1'b1;
        we      = 1'b1;
        addr_d  = SPI_TX;
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        sel    = 1'b1;
        addr_d = SPI_READY;
        cnt_d  = cnt_q + 16'd1;
        // Completion is tested first so it wins over a coincident timeout.
        if (cnt_q >= SETTLE_C && |bus.spi_data_out) begin
          if (rd_q) begin
            state_d = S_RDA;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = S_RSP;
          end
        end else if (cnt_q == POLL_LAST_C) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RSP;
        end
      end
      S_RDA: begin
        sel     = 1'b1;
        addr_d  = SPI_RX;
        state_d = S_RDD;
      end
      S_RDD: begin
        sel        = 1'b1;
        addr_d     = SPI_RX;
        rsp_data_d = bus.spi_data_out;
        rsp_err_d  = 1'b0;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          if (!rsp_err_q) xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = (state_q == S_RSP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.spi_address = addr_d;
  assign bus.spi_data_in = tx_q;
  assign bus.spi_sel     = sel;
  assign bus.spi_we      = we;
  assign busy            = (state_q != S_IDLE);
  assign xfer_cnt        = xfer_cnt_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Randomized bench for spi_xfer_seq with a register-port stub of spi_master and
// an arithmetic timing/response model of each command.
module tb_spi_xfer_seq;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SETTLE = 2;
  localparam int TIMEOUT = 100;
  localparam logic [AW-1:0] A_TX = 4'h0;
  localparam logic [AW-1:0] A_RDY = 4'h1;
  localparam logic [AW-1:0] A_RX = 4'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [15:0] xfer_cnt;

  spi_xfer_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  spi_xfer_seq #(
    .DATA_W(DW), .ADDR_W(AW), .SPI_TX(A_TX), .SPI_READY(A_RDY), .SPI_RX(A_RX),
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub master: READY rises 'delay' cycles after a TX write (or is already high when stale).
  bit stale = 1'b0;
  int delay = 1000000;
  logic [DW-1:0] rx_word = '0;
  int since_tx = 1000000;
  int n_tx = 0, n_we = 0, n_rx = 0;
  logic [DW-1:0] tx_seen = '0;

  always @(posedge clk) begin
    if (bus.spi_sel && bus.spi_we) begin
      n_we <= n_we + 1;
      if (bus.spi_address == A_TX) begin
        n_tx     <= n_tx + 1;
        tx_seen  <= bus.spi_data_in;
        since_tx <= 0;
        bus.spi_data_out <= stale ? 32'd1 : 32'd0;
      end
    end else begin
      if (since_tx < 1000000) since_tx <= since_tx + 1;
      if (bus.spi_sel && bus.spi_address == A_RDY)
        bus.spi_data_out <= (stale || since_tx + 1 >= delay) ? 32'd1 : 32'd0;
      else if (bus.spi_sel && bus.spi_address == A_RX) begin
        n_rx <= n_rx + 1;
        bus.spi_data_out <= rx_word;
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int cmd_no = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [31:0] data, input bit rd, input bit st,
                         input int dly, input int hold, input logic [31:0] rx);
    int m, exp_lat, lat, w, tx0, we0, rx0, e0;
    bit err, bad;
    logic [31:0] exp_data, held;
    m = st ? SETTLE : dly;
    if (m < SETTLE) m = SETTLE;
    err = (m > TIMEOUT - 1);
    exp_lat = err ? TIMEOUT + 1 : 2 + m + (rd ? 2 : 0);
    exp_data = (rd && !err) ? rx : 32'd0;

    @(negedge clk);
    stale = st; delay = dly; rx_word = rx;
    tx0 = n_tx; we0 = n_we; rx0 = n_rx;
    bus.cmd_data = data; bus.cmd_rd = rd; bus.cmd_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    e0 = cyc;
    bus.cmd_valid = 1'b0;

    w = 0;
    @(negedge clk);
    while (!bus.rsp_valid && w < TIMEOUT + 50) begin @(negedge clk); w++; end
    lat = cyc - e0;
    check_eq("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("rsp_data", bus.rsp_data, exp_data);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(err));

    if (hold > 0) begin
      held = bus.rsp_data; bad = 1'b0;
      bus.cmd_valid = 1'b1;
      repeat (hold) begin
        if (bus.cmd_ready || bus.rsp_data !== held || !bus.rsp_valid || bus.rsp_err !== err) bad = 1'b1;
        @(negedge clk);
      end
      if (bus.cmd_ready || bus.rsp_data !== held || !bus.rsp_valid) bad = 1'b1;
      check_eq("backpressure_hold", 32'(bad), 32'd0);
      bus.rsp_ready = 1'b1;
    end

    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    if (!err) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    check_eq("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
    check_eq("idle_ready", {30'd0, busy, bus.cmd_ready}, 32'd1);
    check_eq("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check_eq("tx_writes", 32'(n_tx - tx0), 32'd1);
    check_eq("we_cycles", 32'(n_we - we0), 32'd1);
    check_eq("rx_cycles", 32'(n_rx - rx0), (rd && !err) ? 32'd2 : 32'd0);
    check_eq("tx_word", tx_seen, data);
    $display("[TB] cmd %0d data=0x%08h rd=%0d stale=%0d delay=%0d hold=%0d lat=%0d rsp=0x%08h err=%0d cnt=%0d",
             cmd_no, data, rd, st, dly, hold, lat, bus.rsp_data, bus.rsp_err, xfer_cnt);
    cmd_no++;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check_eq({tag, "_sel_we_busy"}, {29'd0, bus.spi_sel, bus.spi_we, busy}, 32'd0);
    check_eq({tag, "_address"}, 32'(bus.spi_address), 32'd0);
    check_eq({tag, "_data_in"}, bus.spi_data_in, 32'd0);
    check_eq({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'd0);
    check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, dly, w;
    bit st, bad;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_rd = 1'b0; bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    run_cmd(32'hF0F0F0F0, 1'b1, 1'b0, 5, 0, 32'hF0F0F0F0);   // echo read
    run_cmd(32'hABABABAB, 1'b0, 1'b0, 7, 0, $urandom);       // write only
    run_cmd($urandom, 1'b1, 1'b0, 1000000, 0, $urandom);     // READY stuck low
    run_cmd($urandom, 1'b1, 1'b0, 4, 50, $urandom);          // long backpressure
    run_cmd($urandom, 1'b0, 1'b1, 1, 0, $urandom);           // stale READY
    run_cmd($urandom, 1'b1, 1'b1, 1, 3, $urandom);
    run_cmd($urandom, 1'b0, 1'b0, TIMEOUT - 1, 0, $urandom); // completes on last poll
    run_cmd($urandom, 1'b0, 1'b0, TIMEOUT, 0, $urandom);     // one cycle too late

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      st = (r == 1);
      dly = (r == 0) ? TIMEOUT + $urandom_range(0, 20) : $urandom_range(1, 12);
      run_cmd($urandom, 1'($urandom_range(0, 1)), st, dly,
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, $urandom);
    end

    // Reset while polling: response must be dropped and the next command must run normally.
    @(negedge clk);
    stale = 1'b0; delay = 1000000;
    bus.cmd_data = $urandom; bus.cmd_rd = 1'b1; bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("poll_busy", {30'd0, busy, bus.spi_sel}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    exp_cnt = 0;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("ready_after_midreset", 32'(bus.cmd_ready), 32'd1);
    bad = 1'b0;
    repeat (10) begin
      if (bus.rsp_valid || busy) bad = 1'b1;
      @(negedge clk);
    end
    check_eq("no_rsp_after_reset", 32'(bad), 32'd0);
    bus.rsp_ready = 1'b0;
    run_cmd($urandom, 1'b1, 1'b0, 6, 0, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Host-side transfer sequencer that sits directly upstream of `spi_master` and drives its register port (address/data_in/sel/we/data_out). It accepts one command word at a time on a valid/ready stream, writes it to `SPI_TX`, polls `SPI_READY` until the transfer completes, optionally reads `SPI_RX`, and returns exactly one response per command on a valid/ready stream. Software or a DMA engine feeds it, replacing CPU busy-polling of the master.

## Interface
- `DATA_W`, `SPI_DATA_W`: width of command, response and register data.
- `ADDR_W`, `SPI_ADDR_W`: register address width; addresses are `SPI_TX`, `SPI_READY` and `SPI_RX` from `spi_defines.vh`.
- `SETTLE`, 2: number of `SPI_READY` samples discarded after the TX write; range 1..15.
- `TIMEOUT`, 65535: maximum number of polling cycles before the command aborts; 16-bit.
- `clk  in  1` system clock; every register updates on the rising edge.
- `rst  in  1` reset; synchronous and active-high.
- `cmd_valid  in  1` command present.
- `cmd_ready  out  1` command accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_data  in  DATA_W` word to transmit.
- `cmd_rd  in  1` if 1, read `SPI_RX` after the transfer.
- `rsp_valid  out  1` response held until accepted.
- `rsp_ready  in  1` consumer accepts the response.
- `rsp_data  out  DATA_W` RX word; 0 when `cmd_rd=0` or on timeout.
- `rsp_err  out  1` 1 means the transfer timed out.
- `spi_address  out  ADDR_W` connects to master `address`.
- `spi_data_in  out  DATA_W` connects to master `data_in`.
- `spi_sel  out  1`, `spi_we  out  1` connect to master `sel` and `we`.
- `spi_data_out  in  DATA_W` connects to master `data_out`. Read data is valid one cycle after the address is presented with `sel=1`.
- `busy  out  1` high in any state other than IDLE.
- `xfer_cnt  out  16` count of completed, non-timed-out commands; wraps from 0xFFFF to 0.

## Operation
- **IDLE**
  - `cmd_ready = !rsp_valid`.
  - On accept, latch `cmd_data` and `cmd_rd`, then go to WR.
- **WR** (exactly 1 cycle)
  - Drive `spi_sel=1`, `spi_we=1`, `spi_address=SPI_TX`, `spi_data_in`=latched word.
  - Clear the poll counter and go to POLL.
- **POLL**
  - Drive `spi_sel=1`, `spi_we=0`, `spi_address=SPI_READY`. The poll counter increments each cycle.
  - `spi_data_out` is sampled every cycle, but samples are ignored while the counter is below `SETTLE`.
  - The first qualified nonzero sample goes to RDA if `cmd_rd=1`, otherwise to RSP with data 0.
  - If the counter reaches `TIMEOUT`, go to RSP with `rsp_err=1` and data 0.
- **RDA** (1 cycle): drive `spi_sel=1`, `spi_address=SPI_RX`.
- **RDD** (1 cycle): keep `spi_sel=1`, `spi_address=SPI_RX`. Capture `spi_data_out` into `rsp_data` at the end of the cycle.
- **RSP**
  - `rsp_valid=1`, `spi_sel=0`.
  - On `rsp_ready`, clear `rsp_valid` and return to IDLE. `xfer_cnt` increments on that cycle if `rsp_err=0`.
- Outside WR, `spi_we=0`. In IDLE and RSP, `spi_sel=0`.
- `spi_address` holds its last value when `spi_sel=0`.
- `rsp_data` and `rsp_err` remain stable while `rsp_valid=1`.
- A timeout does not reset the master. The next command is still issued normally.

## Timing
- **Reset values:** `cmd_ready=0` during reset and 1 on the first cycle after it; `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `spi_sel=0`, `spi_we=0`, `spi_address=0`, `spi_data_in=0`, `busy=0`, `xfer_cnt=0`; state is IDLE.
- **Reset mid-operation:** all outputs return to reset values on the next edge and any pending response is dropped. The master's transfer is not aborted.
- **Command accept:** accept at edge T. WR occupies cycle T+1. POLL starts at T+2.
- **Read latency:** the first counted READY sample is at T+2+`SETTLE`. If READY is first qualified nonzero at edge P, RDA is P+1, RDD is P+2, and `rsp_valid` rises at P+3.
- **No-read latency:** with `cmd_rd=0`, `rsp_valid` rises at P+1.
- **Throughput:** there are no back-to-back commands. The next `cmd_ready` comes at earliest one cycle after the response handshake.
- **Simultaneous events:**
  - `rsp_ready` already high when `rsp_valid` rises: the handshake completes in that cycle.
  - READY qualifies on the same cycle the counter hits `TIMEOUT`: completion wins and there is no error.

## Test plan
- **Read command:** `cmd_data=0xF0F0F0F0`, `cmd_rd=1`, master looped back to a slave echoing 0xF0F0F0F0 → exactly one TX write with we high for 1 cycle, then `rsp_data=0xF0F0F0F0`, `rsp_err=0`, `xfer_cnt=1`.
- **Write-only command:** 0xABABABAB with `cmd_rd=0` → no `SPI_RX` access, `rsp_data=0`, `rsp_valid` exactly 1 cycle after READY qualifies.
- **Timeout:** stub master with READY stuck at 0, `TIMEOUT=100` → `rsp_err=1`, `rsp_data=0`, `xfer_cnt` unchanged; `rsp_valid` rises 100 poll cycles after POLL starts.
- **Backpressure:** hold `rsp_ready=0` for 50 cycles with `cmd_valid=1` → `cmd_ready=0` and `rsp_data` stable throughout; after release the second command is accepted.
- **Stale READY:** stub READY=1 already at the TX write → first `SETTLE` samples ignored, completion at exactly T+2+`SETTLE`.
- **Reset in POLL:** assert `rst` for 1 cycle during POLL → all outputs at reset values the following cycle, no response emitted, and a new command completes normally.
